// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone command master: FSM states,
// response codes, default widths and the timeout-counter width helper.
package wb_master_pkg;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_BUS_ERR = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;

    // Counter is wide enough for the limit but kept within 8..16 bits.
    function automatic int timeout_cnt_width(input int cyc);
        int w;
        w = $clog2(cyc + 1);
        if (w < 8)
            w = 8;
        if (w > 16)
            w = 16;
        return w;
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYC.
module wb_timeout_cnt
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = timeout_cnt_width(DEF_TIMEOUT_CYC)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    // Count starts at zero in the first bus cycle, so the last allowed cycle holds TIMEOUT_CYC-1.
    assign expire = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator with valid/ready command and response ports.
// Optional bus watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_W-1:0]     cmd_adr,
    input  logic [DATA_W-1:0]     cmd_dat,
    input  logic [DATA_W/8-1:0]   cmd_sel,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_dat,
    output logic [1:0]            rsp_code,

    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [ADDR_W-1:0]     wbm_adr_o,
    output logic [DATA_W-1:0]     wbm_dat_o,
    output logic [DATA_W/8-1:0]   wbm_sel_o,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i,
    input  logic [DATA_W-1:0]     wbm_dat_i
);

    state_e state;
    logic   accept;
    logic   timeout_hit;

    assign accept = (state == IDLE) && cmd_valid && cmd_ready;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (timeout_cnt_width(TIMEOUT_CYC))
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clear  (accept),
        .enable (state == BUS),
        .expire (timeout_hit)
    );
`else
    // No watchdog in this build; the term is constant false and BUS waits forever.
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_code  <= RSP_OK;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        state     <= BUS;
                    end
                end

                // err beats ack, and any real termination beats the watchdog.
                BUS: begin
                    if (wbm_err_i || wbm_ack_i || timeout_hit) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                        if (wbm_err_i) begin
                            rsp_code <= RSP_BUS_ERR;
                            rsp_dat  <= '0;
                        end else if (wbm_ack_i) begin
                            rsp_code <= RSP_OK;
                            rsp_dat  <= wbm_we_o ? '0 : wbm_dat_i;
                        end else begin
                            rsp_code <= RSP_TIMEOUT;
                            rsp_dat  <= '0;
                        end
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master; the timeout scenario
// follows WB_MASTER_TIMEOUT_EN the same way the design does.
module tb_wb_cmd_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_code;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;

    int tests  = 0;
    int failed = 0;

    wb_cmd_master #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (16)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_code  (rsp_code),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .wbm_dat_i (wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Consume the pending response and return to IDLE.
    task automatic drainResponse();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        checkOutput("rst_cyc",       32'(wbm_cyc_o), 32'd0);
        checkOutput("rst_stb",       32'(wbm_stb_o), 32'd0);
        checkOutput("rst_we",        32'(wbm_we_o),  32'd0);
        checkOutput("rst_adr",       wbm_adr_o,      32'd0);
        checkOutput("rst_sel",       32'(wbm_sel_o), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_code",  32'(rsp_code),  32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        wb_rst_i = 1'b0;
        tick();
        checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Zero-wait write
        applyStimulus(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        tick();
        cmd_valid = 1'b0;
        checkOutput("wr_cyc",       32'(wbm_cyc_o), 32'd1);
        checkOutput("wr_stb",       32'(wbm_stb_o), 32'd1);
        checkOutput("wr_we",        32'(wbm_we_o),  32'd1);
        checkOutput("wr_adr",       wbm_adr_o,      32'h3000_0004);
        checkOutput("wr_dat",       wbm_dat_o,      32'hDEAD_BEEF);
        checkOutput("wr_sel",       32'(wbm_sel_o), 32'hF);
        checkOutput("wr_cmd_ready", 32'(cmd_ready), 32'd0);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("wr_cyc_low",   32'(wbm_cyc_o), 32'd0);
        checkOutput("wr_stb_low",   32'(wbm_stb_o), 32'd0);
        checkOutput("wr_rsp_code",  32'(rsp_code),  32'd0);
        checkOutput("wr_rsp_dat",   rsp_dat,        32'd0);
        drainResponse();
        checkOutput("wr_rsp_gone",  32'(rsp_valid), 32'd0);
        checkOutput("wr_ready_back", 32'(cmd_ready), 32'd1);

        // Read with three wait states
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        checkOutput("rd_we",  32'(wbm_we_o), 32'd0);
        checkOutput("rd_adr", wbm_adr_o,     32'h3000_0008);
        tick();
        tick();
        checkOutput("rd_wait_cyc",   32'(wbm_cyc_o), 32'd1);
        checkOutput("rd_wait_valid", 32'(rsp_valid), 32'd0);
        tick();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hFFFF_FFFF;
        checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rd_rsp_dat",   rsp_dat,        32'h1234_5678);
        checkOutput("rd_rsp_code",  32'(rsp_code),  32'd0);
        checkOutput("rd_cyc_low",   32'(wbm_cyc_o), 32'd0);
        drainResponse();

        // ack and err together: err wins
        applyStimulus(1'b0, 32'h3000_000C, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        wbm_dat_i = 32'hAAAA_5555;
        tick();
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        checkOutput("err_rsp_code", 32'(rsp_code),  32'd1);
        checkOutput("err_rsp_dat",  rsp_dat,        32'd0);
        checkOutput("err_cyc_low",  32'(wbm_cyc_o), 32'd0);
        checkOutput("err_rsp_valid", 32'(rsp_valid), 32'd1);
        drainResponse();

        // Response back-pressure with a second command waiting
        applyStimulus(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        tick();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hCAFE_F00D;
        applyStimulus(1'b1, 32'h3000_0014, 32'h5555_AAAA, 4'h3);
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_dat",   rsp_dat,        32'hCAFE_F00D);
            checkOutput("bp_rsp_code",  32'(rsp_code),  32'd0);
            checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            checkOutput("bp_cyc",       32'(wbm_cyc_o), 32'd0);
            tick();
        end
        drainResponse();
        checkOutput("bp_idle_ready", 32'(cmd_ready), 32'd1);
        checkOutput("bp_idle_valid", 32'(rsp_valid), 32'd0);
        tick();
        cmd_valid = 1'b0;
        checkOutput("bp_second_cyc", 32'(wbm_cyc_o), 32'd1);
        checkOutput("bp_second_adr", wbm_adr_o,      32'h3000_0014);
        checkOutput("bp_second_sel", 32'(wbm_sel_o), 32'h3);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        checkOutput("bp_second_dat", rsp_dat, 32'd0);
        drainResponse();

        // Unresponsive slave
        applyStimulus(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        for (int i = 1; i < 16; i++)
            tick();
        checkOutput("to_cyc_last",   32'(wbm_cyc_o), 32'd1);
        checkOutput("to_valid_last", 32'(rsp_valid), 32'd0);
        tick();
        checkOutput("to_cyc_low",   32'(wbm_cyc_o), 32'd0);
        checkOutput("to_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("to_rsp_code",  32'(rsp_code),  32'd2);
        checkOutput("to_rsp_dat",   rsp_dat,        32'd0);
        drainResponse();

        // ack in the expiring cycle beats the timeout
        applyStimulus(1'b0, 32'h3000_0024, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i < 16; i++)
            tick();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h5A5A_5A5A;
        tick();
        wbm_ack_i = 1'b0;
        checkOutput("to_tie_code", 32'(rsp_code), 32'd0);
        checkOutput("to_tie_dat",  rsp_dat,       32'h5A5A_5A5A);
        drainResponse();
`else
        for (int i = 1; i < 40; i++)
            tick();
        checkOutput("hang_cyc",   32'(wbm_cyc_o), 32'd1);
        checkOutput("hang_stb",   32'(wbm_stb_o), 32'd1);
        checkOutput("hang_valid", 32'(rsp_valid), 32'd0);
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        checkOutput("hang_rst_cyc", 32'(wbm_cyc_o), 32'd0);
        tick();
`endif

        // Reset in the middle of a waited read
        applyStimulus(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        checkOutput("mid_cyc", 32'(wbm_cyc_o), 32'd1);
        tick();
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i  = 1'b0;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h7777_7777;
        checkOutput("mid_rst_cyc",   32'(wbm_cyc_o), 32'd0);
        checkOutput("mid_rst_stb",   32'(wbm_stb_o), 32'd0);
        checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(cmd_ready), 32'd0);
        checkOutput("mid_rst_adr",   wbm_adr_o,      32'd0);
        tick();
        wbm_ack_i = 1'b0;
        checkOutput("late_ack_valid", 32'(rsp_valid), 32'd0);
        checkOutput("late_ack_cyc",   32'(wbm_cyc_o), 32'd0);
        checkOutput("late_ack_ready", 32'(cmd_ready), 32'd1);
        applyStimulus(1'b1, 32'h3000_0040, 32'h1122_3344, 4'h3);
        tick();
        cmd_valid = 1'b0;
        checkOutput("after_rst_adr", wbm_adr_o,      32'h3000_0040);
        checkOutput("after_rst_we",  32'(wbm_we_o),  32'd1);
        checkOutput("after_rst_sel", 32'(wbm_sel_o), 32'h3);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        checkOutput("after_rst_valid", 32'(rsp_valid), 32'd1);
        checkOutput("after_rst_code",  32'(rsp_code),  32'd0);
        drainResponse();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
